// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions: word/address widths, opcode constants and fetch FSM states.
package instr_fetch_pkg;

    localparam int CPU_PC_W    = 8;
    localparam int CPU_INSTR_W = 16;
    localparam int OPC_W       = 5;

    localparam logic [CPU_INSTR_W-1:0] NOP_WORD = 16'h0000;

    localparam logic [OPC_W-1:0] OP_NOP  = 5'b00000;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b00001;
    localparam logic [OPC_W-1:0] OP_BZ   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_BNZ  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_JMP  = 5'b01000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+1 and valid, with hold and flush controls.
module instr_fetch_if_id_reg
    import instr_fetch_pkg::*;
#(
    parameter int PC_W    = CPU_PC_W,
    parameter int INSTR_W = CPU_INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic               valid
);

    // Flush inserts a bubble (all-zero word decodes as NOP) and wins over load;
    // with neither asserted the register holds. id_pc is left alone on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= '0;
            pc    <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            pc    <= pc_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, reads the async instruction memory and
// fills the IF/ID register; handles stall, branch redirect and HALT.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | after reset, waiting for start; PC and IF/ID frozen
//   ST_RUN    | fetching one word per cycle unless stalled or redirected
//   ST_HALTED | HALT issued; PC frozen on it, bubbles until a redirect
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int              PC_W     = CPU_PC_W,
    parameter int              INSTR_W  = CPU_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic               id_valid,
    output logic               halted
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_next;
    logic            is_halt;
    logic            fetch;
    logic            flush;

    assign imem_addr = pc;
    assign pc_inc    = pc + 1'b1;
    assign is_halt   = (imem_rdata[INSTR_W-1 -: OPC_W] == OP_HALT);

    // A redirect beats stall; HALTED drains to bubbles whenever ID is not stalled.
    assign fetch = (state == ST_RUN) && !branch_taken && !stall;
    assign flush = (state != ST_IDLE) &&
                   (branch_taken || ((state == ST_HALTED) && !stall));

    // Next-PC select: redirect, sequential increment, or hold (stall / HALT / idle).
    always_comb begin
        pc_next = pc;
        if (state != ST_IDLE) begin
            if (branch_taken)
                pc_next = branch_target;
            else if (fetch && !is_halt)
                pc_next = pc_inc;
        end
    end

    // Fetch FSM with registered PC and halted flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            halted <= 1'b0;
        end else begin
            pc <= pc_next;
            case (state)
                ST_IDLE: begin
                    if (start)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (fetch && is_halt) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (branch_taken) begin
                        state  <= ST_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    instr_fetch_if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (fetch),
        .flush    (flush),
        .instr_in (imem_rdata),
        .pc_in    (pc_inc),
        .instr    (id_instr),
        .pc       (id_pc),
        .valid    (id_valid)
    );

endmodule
